hwag_out_sched: RTL and testbench

Angle-window output scheduler for the hardware angle generator. Drives CH_NUM output channels from the angle counter value. Each channel turns on at a programmed set angle and off at a programmed reset angle. Angle programming uses a valid/ready write port. New angles are staged and committed only at the revolution boundary, so a window in progress is never torn. The block sits downstream of the angle counter and synchronisation logic and replaces fixed threshold comparators on the angle counter.

---
 rtl/hwag_out_sched_if.sv | 33 +++
 rtl/hwag_out_sched.sv | 193 +++++++++++++++++++
 tb/tb_hwag_out_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwag_out_sched_if.sv
// rtl/hwag_out_sched_if.sv - angle programming write port for hwag_out_sched
//
// Signals:
//   wr_valid  write request (master -> slave)
//   wr_ready  write accepted when wr_valid & wr_ready (slave -> master)
//   wr_addr   register address (master -> slave)
//   wr_data   write data (master -> slave)
//   wr_err    one-cycle pulse: accepted write was rejected (slave -> master)
interface hwag_out_sched_if #(
  parameter int ACNT_WIDTH = 24
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [3:0]            wr_addr;
  logic [ACNT_WIDTH-1:0] wr_data;
  logic                  wr_err;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready,
    input  wr_err
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready,
    output wr_err
  );
endinterface

// File: rtl/hwag_out_sched.sv
// rtl/hwag_out_sched.sv - angle-window output scheduler with revolution-boundary commit
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   sync_ok     angle generator synchronised
//   acnt        current angle counter value
//   acnt_step   pulse: acnt advanced this cycle
//   rev_pulse   pulse: acnt wrapped from MAX_ANGLE to 0
//   wr          register write port (slave side)
//   ch_out      per-channel window outputs
//   ch_pending  per-channel staged angles awaiting commit
//
// Register map: 2k = set angle of channel k, 2k+1 = reset angle of channel k,
// 8 = enable mask. Everything else is rejected with wr_err.
module hwag_out_sched #(
  parameter int CH_NUM     = 4,
  parameter int ACNT_WIDTH = 24,
  parameter int MAX_ANGLE  = 3839
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_ok,
  input  logic [ACNT_WIDTH-1:0] acnt,
  input  logic                  acnt_step,
  input  logic                  rev_pulse,
  hwag_out_sched_if.slave       wr,
  output logic [CH_NUM-1:0]     ch_out,
  output logic [CH_NUM-1:0]     ch_pending
);

  localparam logic [ACNT_WIDTH-1:0] MAX_A    = ACNT_WIDTH'(MAX_ANGLE);
  localparam logic [4:0]            ANG_ADDR = 5'(2 * CH_NUM);

  typedef enum logic [1:0] {
    ST_DIS,
    ST_WAIT,
    ST_ACTIVE
  } ch_state_t;

  ch_state_t state_q [CH_NUM];
  ch_state_t state_d [CH_NUM];

  logic [ACNT_WIDTH-1:0] act_set [CH_NUM];
  logic [ACNT_WIDTH-1:0] act_rst [CH_NUM];
  logic [ACNT_WIDTH-1:0] stg_set [CH_NUM];
  logic [ACNT_WIDTH-1:0] stg_rst [CH_NUM];
  logic [CH_NUM-1:0]     en_mask;
  logic [CH_NUM-1:0]     pending;
  logic                  wr_err_q;

  // Write decode
  logic       wr_is_mask;
  logic       wr_is_angle;
  logic       wr_range_ok;
  logic [2:0] wr_ch;
  logic       wr_hi;
  logic       wr_accept;
  logic       wr_ready_c;

  // Channels committing staged angles this cycle
  logic [CH_NUM-1:0] commit;

  assign wr_is_mask  = (wr.wr_addr == 4'd8);
  // The mask address wins if a wide configuration would overlap it.
  assign wr_is_angle = !wr_is_mask && ({1'b0, wr.wr_addr} < ANG_ADDR);
  assign wr_range_ok = (wr.wr_data <= MAX_A);
  assign wr_ch       = wr.wr_addr[3:1];
  assign wr_hi       = wr.wr_addr[0];

  // A channel only commits at a revolution boundary while it is not inside
  // a window, so an open window always closes on the angles it opened with.
  always_comb begin
    commit = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      commit[k] = rev_pulse && pending[k] && (state_q[k] != ST_ACTIVE);
    end
  end

  // Stall a write that would race the staging->active copy of its channel.
  always_comb begin
    wr_ready_c = 1'b1;
    for (int k = 0; k < CH_NUM; k++) begin
      if (wr_is_angle && (wr_ch == 3'(k)) && commit[k]) begin
        wr_ready_c = 1'b0;
      end
    end
  end

  assign wr_accept   = wr.wr_valid && wr_ready_c;
  assign wr.wr_ready = wr_ready_c;
  assign wr.wr_err   = wr_err_q;
  assign ch_pending  = pending;

  // Register file, staging and commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_mask  <= '0;
      pending  <= '0;
      wr_err_q <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
        act_set[k] <= '0;
        act_rst[k] <= '0;
        stg_set[k] <= '0;
        stg_rst[k] <= '0;
      end
    end else begin
      wr_err_q <= 1'b0;

      for (int k = 0; k < CH_NUM; k++) begin
        if (commit[k]) begin
          act_set[k] <= stg_set[k];
          act_rst[k] <= stg_rst[k];
          pending[k] <= 1'b0;
        end
      end

      // A write never targets a committing channel (wr_ready blocks it),
      // so the staging update below cannot collide with the copy above.
      if (wr_accept) begin
        if (wr_is_mask) begin
          en_mask <= wr.wr_data[CH_NUM-1:0];
        end else if (wr_is_angle && wr_range_ok) begin
          for (int k = 0; k < CH_NUM; k++) begin
            if (wr_ch == 3'(k)) begin
              if (wr_hi) begin
                stg_rst[k] <= wr.wr_data;
              end else begin
                stg_set[k] <= wr.wr_data;
              end
              pending[k] <= 1'b1;
            end
          end
        end else begin
          wr_err_q <= 1'b1;
        end
      end
    end
  end

  // Channel FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k] <= ST_DIS;
      end
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k] <= state_d[k];
      end
    end
  end

  // Channel FSM next state. Matching is pure equality on step cycles, so a
  // window that spans the wrap needs no special case. set==reset is an empty
  // window and never opens.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      state_d[k] = state_q[k];
      if (!en_mask[k] || !sync_ok) begin
        state_d[k] = ST_DIS;
      end else begin
        case (state_q[k])
          ST_DIS: begin
            state_d[k] = ST_WAIT;
          end
          ST_WAIT: begin
            if (acnt_step && (acnt == act_set[k]) && (act_set[k] != act_rst[k])) begin
              state_d[k] = ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (acnt_step && (acnt == act_rst[k])) begin
              state_d[k] = ST_WAIT;
            end
          end
          default: begin
            state_d[k] = ST_DIS;
          end
        endcase
      end
    end
  end

  // Output follows the state register directly, so reset clears it at once.
  always_comb begin
    ch_out = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      ch_out[k] = (state_q[k] == ST_ACTIVE);
    end
  end

endmodule

// File: tb/tb_hwag_out_sched.sv
// tb/tb_hwag_out_sched.sv - self-checking bench for hwag_out_sched
module tb_hwag_out_sched;
  localparam int CH  = 4;
  localparam int W   = 24;
  localparam int MAX = 3839;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync_ok;
  logic [W-1:0]  acnt;
  logic          acnt_step;
  logic          rev_pulse;
  logic [CH-1:0] ch_out;
  logic [CH-1:0] ch_pending;

  hwag_out_sched_if #(.ACNT_WIDTH(W)) bus ();

  hwag_out_sched #(
    .CH_NUM(CH),
    .ACNT_WIDTH(W),
    .MAX_ANGLE(MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sync_ok(sync_ok),
    .acnt(acnt),
    .acnt_step(acnt_step),
    .rev_pulse(rev_pulse),
    .wr(bus),
    .ch_out(ch_out),
    .ch_pending(ch_pending)
  );

  always #5 clk = ~clk;

  // Reference model: window open flag per channel plus the programmed angles.
  // mode: 0 = disabled, 1 = armed, 2 = output on
  int m_set [CH];
  int m_rst [CH];
  int s_set [CH];
  int s_rst [CH];
  bit m_pend [CH];
  bit m_en [CH];
  int m_mode [CH];
  bit m_err;
  int cur;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (angle %0d, t=%0t)", name, act, exp, cur, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_set[k] = 0; m_rst[k] = 0; s_set[k] = 0; s_rst[k] = 0;
      m_pend[k] = 0; m_en[k] = 0; m_mode[k] = 0;
    end
    m_err = 0;
  endtask

  // One clock: drive at the falling edge, predict, compare at the next falling edge.
  task automatic cycle(input bit stp, input bit wv, input int a, input int d);
    int nxt;
    bit rv, rdy, acc;
    bit cmt [CH];
    logic [CH-1:0] e_out, e_pend;
    nxt = cur;
    if (stp) nxt = (cur == MAX) ? 0 : cur + 1;
    rv = stp && (nxt == 0);
    acnt = W'(nxt);
    acnt_step = stp;
    rev_pulse = rv;
    bus.wr_valid = wv;
    bus.wr_addr = a[3:0];
    bus.wr_data = d[W-1:0];
    #1;
    rdy = 1'b1;
    if (a < 2 * CH) rdy = !(m_pend[a / 2] && rv && m_mode[a / 2] != 2);
    check("wr_ready", {31'd0, bus.wr_ready}, {31'd0, rdy});
    acc = wv && rdy;
    for (int k = 0; k < CH; k++) cmt[k] = rv && m_pend[k] && m_mode[k] != 2;
    for (int k = 0; k < CH; k++) begin
      if (!m_en[k] || !sync_ok) m_mode[k] = 0;
      else if (m_mode[k] == 0) m_mode[k] = 1;
      else if (m_mode[k] == 1 && stp && nxt == m_set[k] && m_set[k] != m_rst[k]) m_mode[k] = 2;
      else if (m_mode[k] == 2 && stp && nxt == m_rst[k]) m_mode[k] = 1;
    end
    for (int k = 0; k < CH; k++) begin
      if (cmt[k]) begin
        m_set[k] = s_set[k]; m_rst[k] = s_rst[k]; m_pend[k] = 0;
      end
    end
    m_err = 0;
    if (acc) begin
      if (a == 8) begin
        for (int k = 0; k < CH; k++) m_en[k] = ((d >> k) & 1) != 0;
      end else if (a < 2 * CH && d >= 0 && d <= MAX) begin
        if (a % 2 == 1) s_rst[a / 2] = d; else s_set[a / 2] = d;
        m_pend[a / 2] = 1;
      end else begin
        m_err = 1;
      end
    end
    cur = nxt;
    @(negedge clk);
    for (int k = 0; k < CH; k++) begin
      e_out[k] = (m_mode[k] == 2);
      e_pend[k] = m_pend[k];
    end
    check("ch_out", 32'(ch_out), 32'(e_out));
    check("ch_pending", 32'(ch_pending), 32'(e_pend));
    check("wr_err", {31'd0, bus.wr_err}, {31'd0, m_err});
    acnt_step = 1'b0;
    rev_pulse = 1'b0;
    bus.wr_valid = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic step_to(input int target);
    int n;
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 0, 0);
      n++;
    end while (cur != target && n < 4000);
    check("step_to_reached", 32'(cur), 32'(target));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stp, wv;
    int a, d;

    rst = 1'b0;
    sync_ok = 1'b0;
    acnt = '0;
    acnt_step = 1'b0;
    rev_pulse = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    cur = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ch_out", 32'(ch_out), 32'd0);
    check("rst_ch_pending", 32'(ch_pending), 32'd0);
    check("rst_wr_err", {31'd0, bus.wr_err}, 32'd0);
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    rst = 1'b1;
    sync_ok = 1'b1;

    // Program ch0 100..200 and ch1 3800..40 (wrapping), enable both
    wr(0, 100);
    wr(1, 200);
    check("pend_after_ch0", 32'(ch_pending), 32'h1);
    wr(2, 3800);
    wr(3, 40);
    wr(8, 3);
    check("pend_after_ch1", 32'(ch_pending), 32'h3);

    // Rejections leave everything untouched
    wr(0, 3840);
    check("rej_range_err", {31'd0, bus.wr_err}, 32'd1);
    check("rej_range_pend", 32'(ch_pending), 32'h3);
    wr(12, 5);
    check("rej_addr_err", {31'd0, bus.wr_err}, 32'd1);
    cycle(1'b0, 1'b0, 0, 0);
    check("err_one_cycle", {31'd0, bus.wr_err}, 32'd0);

    // Commit at the wrap, then the basic window
    step_to(0);
    check("commit_pend", 32'(ch_pending), 32'd0);
    step_to(99);  check("w0_99", {31'd0, ch_out[0]}, 32'd0);
    step_to(100); check("w0_100", {31'd0, ch_out[0]}, 32'd1);
    step_to(199); check("w0_199", {31'd0, ch_out[0]}, 32'd1);
    step_to(200); check("w0_200", {31'd0, ch_out[0]}, 32'd0);

    // Wrapping window
    step_to(3799); check("w1_3799", {31'd0, ch_out[1]}, 32'd0);
    step_to(3800); check("w1_3800", {31'd0, ch_out[1]}, 32'd1);
    step_to(0);    check("w1_0", {31'd0, ch_out[1]}, 32'd1);
    step_to(39);   check("w1_39", {31'd0, ch_out[1]}, 32'd1);
    step_to(40);   check("w1_40", {31'd0, ch_out[1]}, 32'd0);

    // Deferred commit while the window is open
    step_to(150); check("def_on", {31'd0, ch_out[0]}, 32'd1);
    wr(0, 500);
    wr(1, 600);
    check("def_pend", 32'(ch_pending), 32'h1);
    step_to(200);  check("def_old_end", {31'd0, ch_out[0]}, 32'd0);
    step_to(3839); check("def_still_pend", 32'(ch_pending), 32'h1);
    step_to(0);    check("def_commit", 32'(ch_pending), 32'd0);
    step_to(100);  check("def_100", {31'd0, ch_out[0]}, 32'd0);
    step_to(500);  check("def_500", {31'd0, ch_out[0]}, 32'd1);
    step_to(600);  check("def_600", {31'd0, ch_out[0]}, 32'd0);

    wr(0, 100);
    wr(1, 200);
    step_to(0);

    // sync_ok drop mid-window, re-assert inside the window
    step_to(150); check("sync_on", {31'd0, ch_out[0]}, 32'd1);
    sync_ok = 1'b0;
    cycle(1'b0, 1'b0, 0, 0);
    check("sync_drop", {31'd0, ch_out[0]}, 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 0, 0);
    sync_ok = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 0, 0);
    step_to(200); check("sync_stay_low", {31'd0, ch_out[0]}, 32'd0);
    step_to(99);  check("sync_99", {31'd0, ch_out[0]}, 32'd0);
    step_to(100); check("sync_rearm", {31'd0, ch_out[0]}, 32'd1);

    // Asynchronous reset mid-window
    step_to(150); check("rst_pre", {31'd0, ch_out[0]}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", 32'(ch_out), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check("rst_pend_clear", 32'(ch_pending), 32'd0);
    step_to(120); check("rst_mask0", 32'(ch_out), 32'd0);

    // Only the reset half written: set keeps its active value of 0.
    // At the commit wrap the step at 0 still sees the old empty window.
    wr(1, 50);
    wr(8, 1);
    step_to(0);  check("z_commit_old", {31'd0, ch_out[0]}, 32'd0);
    check("z_pend", 32'(ch_pending), 32'd0);
    step_to(1);  check("z_1", {31'd0, ch_out[0]}, 32'd0);
    step_to(0);  check("z_0_on", {31'd0, ch_out[0]}, 32'd1);
    step_to(49); check("z_49", {31'd0, ch_out[0]}, 32'd1);
    step_to(50); check("z_50", {31'd0, ch_out[0]}, 32'd0);

    // Randomised traffic, with writes forced onto every wrap cycle
    for (int i = 0; i < 10000; i++) begin
      stp = ($urandom % 5) != 0;
      if (stp && cur == MAX) wv = 1'b1;
      else wv = ($urandom % 4) == 0;
      if (($urandom % 8) == 0) a = int'($urandom % 16);
      else a = int'($urandom % 9);
      if (a == 8) d = int'($urandom % 16);
      else if (($urandom % 16) == 0) d = MAX + 1 + int'($urandom % 100);
      else d = int'($urandom % (MAX + 1));
      if (($urandom % 500) == 0) sync_ok = ~sync_ok;
      cycle(stp, wv, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
